// File: rtl/expr_pkg.sv
// Shared definitions for the expression lexer: token codes, FSM states,
// character classes and the ASCII constants the classifier matches on.
package expr_pkg;

    localparam int VAL_W = 16;

    typedef enum logic [2:0] {
        TOK_NUM = 3'd0,
        TOK_ADD = 3'd1,
        TOK_SUB = 3'd2,
        TOK_MUL = 3'd3,
        TOK_EQ  = 3'd4,
        TOK_END = 3'd5,
        TOK_ERR = 3'd7
    } tok_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NUM  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CC_DIGIT = 3'd0,
        CC_OP    = 3'd1,
        CC_SPACE = 3'd2,
        CC_TERM  = 3'd3,
        CC_BAD   = 3'd4
    } char_class_e;

    localparam logic [7:0] CH_0     = 8'h30;  // '0'
    localparam logic [7:0] CH_9     = 8'h39;  // '9'
    localparam logic [7:0] CH_PLUS  = 8'h2B;  // '+'
    localparam logic [7:0] CH_MINUS = 8'h2D;  // '-'
    localparam logic [7:0] CH_STAR  = 8'h2A;  // '*'
    localparam logic [7:0] CH_EQ    = 8'h3D;  // '='
    localparam logic [7:0] CH_SPACE = 8'h20;  // ' '
    localparam logic [7:0] CH_SEMI  = 8'h3B;  // ';'
    localparam logic [7:0] CH_NUL   = 8'h00;

    // acc*10 + digit, truncated to the value width (silent wrap)
    function automatic logic [VAL_W-1:0] acc_step(input logic [VAL_W-1:0] acc,
                                                  input logic [3:0] digit);
        logic [VAL_W-1:0] times10;
        times10  = (acc << 3) + (acc << 1);
        acc_step = times10 + {{(VAL_W-4){1'b0}}, digit};
    endfunction

endpackage

// File: rtl/expr_lexer_if.sv
// Character-in / token-out stream bundle. The master side feeds characters
// and consumes tokens; the slave side is the lexer.
interface expr_lexer_if;
    import expr_pkg::*;

    logic [7:0]       in_char;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       tok_kind;
    logic [VAL_W-1:0] tok_val;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_char, in_valid, out_ready,
        input  in_ready, tok_kind, tok_val, out_valid
    );

    modport slave (
        input  in_char, in_valid, out_ready,
        output in_ready, tok_kind, tok_val, out_valid
    );

endinterface

// File: rtl/expr_char_class.sv
// Purely combinational character classifier: class, digit value and the
// operator token a character maps to.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_e cls,
    output logic [3:0]  digit,
    output tok_kind_e   op_kind
);

    logic [7:0] ch_off;
    assign ch_off = ch - CH_0;

    // Decode the character into its class and payload
    always_comb begin
        cls     = CC_BAD;
        digit   = 4'd0;
        op_kind = TOK_ERR;
        if (ch >= CH_0 && ch <= CH_9) begin
            cls   = CC_DIGIT;
            digit = ch_off[3:0];
        end else begin
            case (ch)
                CH_PLUS:  begin cls = CC_OP; op_kind = TOK_ADD; end
                CH_MINUS: begin cls = CC_OP; op_kind = TOK_SUB; end
                CH_STAR:  begin cls = CC_OP; op_kind = TOK_MUL; end
                CH_EQ:    begin cls = CC_OP; op_kind = TOK_EQ;  end
                CH_SPACE: cls = CC_SPACE;
                CH_SEMI:  cls = CC_TERM;
                CH_NUL:   cls = CC_TERM;
                default:  cls = CC_BAD;
            endcase
        end
    end

endmodule

// File: rtl/expr_lexer.sv
// Streaming arithmetic-expression lexer. Turns a character stream into
// NUM/operator/END/ERR tokens through a single registered output slot.
// A number terminated by an operator or terminator produces two tokens;
// the second is parked in HOLD until the output slot frees.
module expr_lexer
    import expr_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    expr_lexer_if.slave  bus
);

    state_e           state_reg, state_next;
    logic [VAL_W-1:0] acc_reg, acc_next;
    tok_kind_e        pend_reg, pend_next;

    tok_kind_e        tok_kind_reg;
    logic [VAL_W-1:0] tok_val_reg;
    logic             out_valid_reg;

    logic             emit;
    tok_kind_e        emit_kind;
    logic [VAL_W-1:0] emit_val;

    char_class_e      cls;
    logic [3:0]       digit;
    tok_kind_e        op_kind;

    logic             slot_free;
    logic             accept;

    expr_char_class u_class (
        .ch      (bus.in_char),
        .cls     (cls),
        .digit   (digit),
        .op_kind (op_kind)
    );

    // The output slot can take a new token when empty or being drained now;
    // reset is folded in so the source sees in_ready low during reset.
    assign slot_free    = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = reset && (state_reg != ST_HOLD) && slot_free;
    assign accept       = bus.in_valid && bus.in_ready;

    // State register together with the accumulator and parked token
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            pend_reg  <= TOK_END;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            pend_reg  <= pend_next;
        end
    end

    // Next-state decision
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (cls == CC_DIGIT)    state_next = ST_NUM;
                    else if (cls == CC_BAD) state_next = ST_ERR;
                end
            end
            ST_NUM: begin
                if (accept) begin
                    case (cls)
                        CC_SPACE: state_next = ST_IDLE;
                        CC_OP:    state_next = ST_HOLD;
                        CC_TERM:  state_next = ST_HOLD;
                        CC_BAD:   state_next = ST_ERR;
                        default:  state_next = ST_NUM;
                    endcase
                end
            end
            ST_HOLD: begin
                if (slot_free) state_next = ST_IDLE;
            end
            ST_ERR: begin
                if (accept && cls == CC_TERM) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Token emission and datapath updates for the current state/char
    always_comb begin
        emit      = 1'b0;
        emit_kind = TOK_NUM;
        emit_val  = '0;
        acc_next  = acc_reg;
        pend_next = pend_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (cls)
                        CC_DIGIT: acc_next = {{(VAL_W-4){1'b0}}, digit};
                        CC_OP:    begin emit = 1'b1; emit_kind = op_kind; end
                        CC_TERM:  begin emit = 1'b1; emit_kind = TOK_END; end
                        CC_BAD:   begin emit = 1'b1; emit_kind = TOK_ERR; end
                        default:  ;
                    endcase
                end
            end
            ST_NUM: begin
                if (accept) begin
                    case (cls)
                        CC_DIGIT: acc_next = acc_step(acc_reg, digit);
                        CC_SPACE: begin
                            emit = 1'b1; emit_kind = TOK_NUM; emit_val = acc_reg;
                        end
                        CC_OP: begin
                            emit = 1'b1; emit_kind = TOK_NUM; emit_val = acc_reg;
                            pend_next = op_kind;
                        end
                        CC_TERM: begin
                            emit = 1'b1; emit_kind = TOK_NUM; emit_val = acc_reg;
                            pend_next = TOK_END;
                        end
                        default: begin
                            emit = 1'b1; emit_kind = TOK_ERR; acc_next = '0;
                        end
                    endcase
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    emit = 1'b1; emit_kind = pend_reg;
                end
            end
            ST_ERR: begin
                if (accept && cls == CC_TERM) begin
                    emit = 1'b1; emit_kind = TOK_END;
                end
            end
            default: ;
        endcase
    end

    // Output slot: load on emit, clear when consumed, hold while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            tok_kind_reg  <= TOK_NUM;
            tok_val_reg   <= '0;
        end else if (emit) begin
            out_valid_reg <= 1'b1;
            tok_kind_reg  <= emit_kind;
            tok_val_reg   <= emit_val;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.tok_kind  = tok_kind_reg;
    assign bus.tok_val   = tok_val_reg;

endmodule
